// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 8;
    localparam int unsigned PRESC_WIDTH_DEF = 6;

    localparam logic [PRESC_WIDTH_DEF-1:0] PRESC_8  = 6'd8;
    localparam logic [PRESC_WIDTH_DEF-1:0] PRESC_16 = 6'd16;
    localparam logic [PRESC_WIDTH_DEF-1:0] PRESC_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter (wraps at prescale-1) and payload bit counter.
// o_bit_end_c is a combinational strobe on the last oversample of a bit.
module uart_rx_edge_bit_cnt #(
    parameter int unsigned PRESC_WIDTH = 6,
    parameter int unsigned BIT_CNT_W   = 3
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_bit_inc,
    input  logic                   i_bit_clr,
    input  logic [PRESC_WIDTH-1:0] i_prescale,
    output logic [PRESC_WIDTH-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]   o_bit_cnt,
    output logic                   o_bit_end_c
);

    logic [PRESC_WIDTH-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   w_bit_end;

    assign w_bit_end = i_en && (r_edge_cnt == (i_prescale - PRESC_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (!i_en || w_bit_end) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESC_WIDTH'(1);
            end
            if (i_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (i_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    assign o_edge_cnt  = r_edge_cnt;
    assign o_bit_cnt   = r_bit_cnt;
    assign o_bit_end_c = w_bit_end;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, LSB-first deserialize, parity/stop check.
// Optional UART_RX_ERR_CNT_EN adds a saturating frame-error counter output err_cnt.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned PRESC_WIDTH = PRESC_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RX_IN,
    input  logic [PRESC_WIDTH-1:0] prescale,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   sampled_bit,
    output logic                   data_samp_en,
    output logic [PRESC_WIDTH-1:0] edge_cnt,
    output logic [DATA_WIDTH-1:0]  P_DATA,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err,
    output logic                   busy
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]             err_cnt
`endif
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH);

    uart_rx_state_e         r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_p_data, w_p_data_nxt;
    logic                   r_par_en, w_par_en_nxt;
    logic                   r_par_typ, w_par_typ_nxt;
    logic                   r_par_err, w_par_err_nxt;
    logic                   r_stp_err, w_stp_err_nxt;
    logic                   r_data_valid, w_data_valid_nxt;
    logic                   r_busy;
    logic                   w_bit_inc, w_bit_clr, w_bit_end;
    logic [BIT_CNT_W-1:0]   w_bit_cnt;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0]             r_err_cnt;
    logic                   w_err_inc;
`endif

    uart_rx_edge_bit_cnt #(
        .PRESC_WIDTH (PRESC_WIDTH),
        .BIT_CNT_W   (BIT_CNT_W)
    ) u_cnt (
        .clk         (clk),
        .i_rst_n     (rst),
        .i_en        (r_state != IDLE),
        .i_bit_inc   (w_bit_inc),
        .i_bit_clr   (w_bit_clr),
        .i_prescale  (prescale),
        .o_edge_cnt  (edge_cnt),
        .o_bit_cnt   (w_bit_cnt),
        .o_bit_end_c (w_bit_end)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_p_data     <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
            r_err_cnt    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_p_data     <= w_p_data_nxt;
            r_par_en     <= w_par_en_nxt;
            r_par_typ    <= w_par_typ_nxt;
            r_par_err    <= w_par_err_nxt;
            r_stp_err    <= w_stp_err_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_busy       <= (w_state_nxt != IDLE);
`ifdef UART_RX_ERR_CNT_EN
            if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
`endif
        end
    end

    // Next-state and next-output decode; decisions only at bit end
    always_comb begin
        w_state_nxt      = r_state;
        w_p_data_nxt     = r_p_data;
        w_par_en_nxt     = r_par_en;
        w_par_typ_nxt    = r_par_typ;
        w_par_err_nxt    = r_par_err;
        w_stp_err_nxt    = r_stp_err;
        w_data_valid_nxt = 1'b0;
        w_bit_inc        = 1'b0;
        w_bit_clr        = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
        w_err_inc        = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!RX_IN) begin
                    w_state_nxt   = START;
                    w_par_en_nxt  = PAR_EN;
                    w_par_typ_nxt = PAR_TYP;
                    w_par_err_nxt = 1'b0;
                    w_stp_err_nxt = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    if (!sampled_bit) begin
                        w_state_nxt = DATA;
                        w_bit_clr   = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
`ifdef UART_RX_ERR_CNT_EN
                        w_err_inc   = 1'b1;
`endif
                    end
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_p_data_nxt = {sampled_bit, r_p_data[DATA_WIDTH-1:1]};
                    if (w_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        w_bit_clr   = 1'b1;
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_inc   = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_par_err_nxt = (sampled_bit != ((^r_p_data) ^ r_par_typ));
                    w_state_nxt   = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_stp_err_nxt    = ~sampled_bit;
                    w_data_valid_nxt = sampled_bit && !r_par_err;
                    w_state_nxt      = IDLE;
`ifdef UART_RX_ERR_CNT_EN
                    w_err_inc        = !sampled_bit || r_par_err;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign data_samp_en = r_busy;
    assign busy         = r_busy;
    assign P_DATA       = r_p_data;
    assign data_valid   = r_data_valid;
    assign par_err      = r_par_err;
    assign stp_err      = r_stp_err;
`ifdef UART_RX_ERR_CNT_EN
    assign err_cnt      = r_err_cnt;
`endif

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Frame controller for the UART receiver. It detects the start edge and runs the edge and bit counters that drive the majority-vote sampler (data_samp_en, edge_cnt). It consumes the sampler's sampled_bit, deserializes LSB-first, and checks start glitch, optional parity and stop bit. It sits between the RX pin synchronizer and the RX byte consumer (bus/FIFO).

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESC_WIDTH, 6, width of prescale and edge_cnt

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
RX_IN  in  1  synchronized serial input, idle high
prescale  in  6  oversampling ratio; legal 8, 16, 32; change only while busy=0
PAR_EN  in  1  parity bit present
PAR_TYP  in  1  0 even, 1 odd
sampled_bit  in  1  majority-voted bit from sampler
data_samp_en  out  1  sampler enable
edge_cnt  out  6  oversample index within current bit, 0..prescale-1
P_DATA  out  8  received byte
data_valid  out  1  one-cycle pulse, byte good
par_err  out  1  parity error of last frame
stp_err  out  1  stop error of last frame
busy  out  1  frame in progress

Behaviour:
- Reset (rst=0 at posedge clk): state IDLE; edge_cnt=0, bit_cnt=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0, data_samp_en=0, busy=0. Reset mid-frame aborts the frame with no data_valid.
- States: IDLE, START, DATA, PARITY, STOP (encoding in package).
- data_samp_en=1 and busy=1 in every state except IDLE.
- IDLE: edge_cnt held 0. RX_IN==0 sampled -> START next cycle with edge_cnt=0. PAR_EN and PAR_TYP latched on this transition; par_err and stp_err cleared.
- Non-IDLE: edge_cnt increments each clk; at edge_cnt==prescale-1 ("bit end") it wraps to 0 and the state decision below is taken. sampled_bit is read only at bit end; the sampler updates it at prescale/2+1, so it is stable by then.
- START bit end: sampled_bit==0 -> DATA, bit_cnt=0. sampled_bit==1 -> glitch -> IDLE, no error flags.
- DATA bit end: P_DATA <= {sampled_bit, P_DATA[7:1]} (LSB first); bit_cnt++.
  - bit_cnt==DATA_WIDTH-1 -> PARITY if latched PAR_EN, else STOP.
  - bit_cnt is 3 bits and wraps to 0 on exit.
- PARITY bit end: expected = ^P_DATA XOR PAR_TYP. par_err <= (sampled_bit != expected). -> STOP.
- STOP bit end: stp_err <= ~sampled_bit. data_valid=1 for the following single cycle iff the new stp_err==0 and par_err==0. -> IDLE.
- Error flags hold until the next IDLE->START transition.
- P_DATA holds between frames and only updates in DATA.
- Back-to-back frames: a start bit beginning right after the stop bit end is detected one cycle late in IDLE; tolerated, as it is within the half-bit sampling margin.
- prescale change while busy=1: undefined; prescale is quasi-static.

Optional Feature:
UART_RX_ERR_CNT_EN:
- Defined: adds output err_cnt [7:0]. It increments, saturating at 255, on each STOP bit end with par_err|stp_err set, and on each START glitch. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package uart_rx_pkg: state enum (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit), PRESC_8/16/32 constants, DATA_WIDTH default.
- Sub-module uart_rx_edge_bit_cnt: edge counter with wrap at prescale-1, bit counter, and bit-end strobe. Controlled by enable and bit-increment inputs from the FSM.

Test Plan:
- prescale=8, PAR_EN=0, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> P_DATA=0xA5; one data_valid pulse; busy high exactly 80 cycles; par_err=stp_err=0.
- prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C with parity bit 0 -> data_valid, par_err=0. Repeat with parity bit 1 -> par_err=1, no data_valid, P_DATA=0x3C.
- prescale=8, RX_IN low for 3 cycles then high -> START glitch, return to IDLE at edge_cnt wrap, no data_valid, flags 0 (err_cnt=1 if UART_RX_ERR_CNT_EN).
- prescale=32, byte 0xFF with stop bit 0 -> stp_err=1, no data_valid, flag cleared on next start edge.
- Two back-to-back 0x55, 0xAA frames at prescale=8, no idle gap -> two data_valid pulses, P_DATA 0x55 then 0xAA.
- rst=0 asserted in the middle of DATA bit 4 -> next cycle all outputs at reset values; a following clean frame 0x81 received correctly.
